// File: rtl/fsm_sequence_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_sequence_ctrl_if
//  Purpose  : Bundles the word-producer handshake, the detector link and the
//             result handshake of the sequence controller.
//  Signals  : in_valid/in_ready/in_word    - word input handshake
//             det_reset/det_w/det_z        - link to the 1101 detector
//             out_valid/out_ready/out_count/out_hit - result handshake
//  Modports : slave  - the controller side
//             master - the environment (producer, detector, consumer)
//  Revision : 1.0 - initial release
// ============================================================================
interface fsm_sequence_ctrl_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              det_reset;
  logic              det_w;
  logic              det_z;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              out_hit;

  modport slave (
    input  in_valid, in_word, det_z, out_ready,
    output in_ready, det_reset, det_w, out_valid, out_count, out_hit
  );

  modport master (
    output in_valid, in_word, det_z, out_ready,
    input  in_ready, det_reset, det_w, out_valid, out_count, out_hit
  );
endinterface
`default_nettype wire

// File: rtl/fsm_sequence_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_sequence_ctrl
//  Purpose  : Accepts a parallel word, clears the external 1101 detector for
//             one cycle, shifts the word MSB first into it, counts the
//             detector's z pulses (saturating) and reports the count over a
//             valid/ready handshake.
//  Ports    : clock - rising-edge system clock
//             reset - asynchronous active-low reset
//             bus   - fsm_sequence_ctrl_if.slave (word in, detector link,
//                     result out)
//  Params   : WORD_W - bits per word (>= 4); must match the interface
//             CNT_W  - match counter width; must match the interface
//  Revision : 1.0 - initial release
// ============================================================================
module fsm_sequence_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                clock,
  input  logic                reset,
  fsm_sequence_ctrl_if.slave  bus
);

  localparam int                 c_bit_w    = $clog2(WORD_W);
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(WORD_W - 1);
  localparam logic [CNT_W-1:0]   c_cnt_max  = {CNT_W{1'b1}};

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_clear  = 2'd1;
  localparam logic [1:0] c_shift  = 2'd2;
  localparam logic [1:0] c_report = 2'd3;

  logic [1:0]         r_state;
  logic [WORD_W-1:0]  r_shift;
  logic [c_bit_w-1:0] r_bit_cnt;
  logic [CNT_W-1:0]   r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= c_idle;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.in_valid) begin
            r_shift <= bus.in_word;
            r_count <= '0;
            r_state <= c_clear;
          end
        end
        c_clear: begin
          // Detector is held in reset this cycle, so the first bit it sees
          // at the next edge starts from its initial state.
          r_bit_cnt <= c_last_bit;
          r_state   <= c_shift;
        end
        c_shift: begin
          // det_z is the Mealy output for the bit currently on det_w.
          if (bus.det_z && (r_count != c_cnt_max)) begin
            r_count <= r_count + 1'b1;
          end
          r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt - 1'b1;
          if (r_bit_cnt == '0) begin
            r_state <= c_report;
          end
        end
        c_report: begin
          if (bus.out_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == c_idle);
  assign bus.det_reset = (r_state == c_clear);
  assign bus.det_w     = (r_state == c_shift) & r_shift[WORD_W-1];
  assign bus.out_valid = (r_state == c_report);
  assign bus.out_count = r_count;
  assign bus.out_hit   = |r_count;

endmodule
`default_nettype wire

// File: tb/tb_fsm_sequence_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_sequence_ctrl
//  Purpose  : Scoreboard bench for fsm_sequence_ctrl. Models the 1101 Mealy
//             detector, drives directed words, queues expected counts and
//             pops/compares them on each result handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_sequence_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fsm_sequence_ctrl_if #(.WORD_W(8),  .CNT_W(4)) bus ();
  fsm_sequence_ctrl_if #(.WORD_W(32), .CNT_W(2)) bus32 ();

  fsm_sequence_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  fsm_sequence_ctrl #(.WORD_W(32), .CNT_W(2)) dut32 (
    .clock (clock),
    .reset (reset),
    .bus   (bus32.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int exp_q32[$];
  int mon_e;
  int mon_e32;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // 1101 detector model: A=0, B=1 (1), C=2 (11, a further 1 stays), D=3 (110).
  // A 1 in D is a match and returns to A, so matches never overlap.
  function automatic logic [1:0] det_next(input logic [1:0] st, input logic w);
    case (st)
      2'd0:    det_next = w ? 2'd1 : 2'd0;
      2'd1:    det_next = w ? 2'd2 : 2'd0;
      2'd2:    det_next = w ? 2'd2 : 2'd3;
      default: det_next = 2'd0;
    endcase
  endfunction

  logic [1:0] det_st   = 2'd0;
  logic [1:0] det_st32 = 2'd0;

  assign bus.det_z   = (det_st == 2'd3) && bus.det_w;
  assign bus32.det_z = (det_st32 == 2'd3) && bus32.det_w;

  always @(posedge clock) begin
    det_st   <= bus.det_reset   ? 2'd0 : det_next(det_st, bus.det_w);
    det_st32 <= bus32.det_reset ? 2'd0 : det_next(det_st32, bus32.det_w);
  end

  // Result monitors: compare on every completed output handshake.
  always @(negedge clock) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_count", int'(bus.out_count), mon_e);
        chk("out_hit", int'(bus.out_hit), int'(mon_e != 0));
      end
    end
  end

  always @(negedge clock) begin
    if (bus32.out_valid && bus32.out_ready) begin
      if (exp_q32.size() == 0) begin
        chk("unexpected_result32", 1, 0);
      end else begin
        mon_e32 = exp_q32.pop_front();
        chk("out_count32", int'(bus32.out_count), mon_e32);
        chk("out_hit32", int'(bus32.out_hit), int'(mon_e32 != 0));
      end
    end
  end

  // Stimulus helpers: all called #1 after a rising edge.
  task automatic wait_in_ready();
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clock); #1; n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [7:0] w, input int exp, input bit trace);
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    wait_in_ready();
    exp_q.push_back(exp);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    if (trace) begin
      chk("det_reset_clear", int'(bus.det_reset), 1);
      chk("det_w_clear", int'(bus.det_w), 0);
      for (int i = 0; i < 8; i++) begin
        @(posedge clock); #1;
        chk("det_reset_shift", int'(bus.det_reset), 0);
        chk("det_w_bit", int'(bus.det_w), int'(w[7-i]));
      end
      @(posedge clock); #1;
      chk("out_valid_latency", int'(bus.out_valid), 1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_q32.size() != 0) && n < 200) begin
      @(posedge clock); #1; n++;
    end
    if (exp_q.size() != 0 || exp_q32.size() != 0)
      chk("drain_timeout", exp_q.size() + exp_q32.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  int'(bus.in_ready),  1);
    chk({tag, "_det_reset"}, int'(bus.det_reset), 0);
    chk({tag, "_det_w"},     int'(bus.det_w),     0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_count"}, int'(bus.out_count), 0);
    chk({tag, "_out_hit"},   int'(bus.out_hit),   0);
  endtask

  initial begin
    int n;
    int seen;
    bus.in_valid    = 1'b0;
    bus.in_word     = '0;
    bus.out_ready   = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.in_word   = '0;
    bus32.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clock); #1;

    // Single match, full bit trace and latency
    send_word(8'b1101_0000, 1, 1'b1);
    wait_drain();
    @(posedge clock); #1;
    chk("out_valid_one_cycle", int'(bus.out_valid), 0);
    chk("idle_after_report", int'(bus.in_ready), 1);

    // Assorted patterns
    send_word(8'b1101_1101, 2, 1'b0);
    wait_drain();
    send_word(8'b1110_1000, 1, 1'b0);
    wait_drain();
    send_word(8'h00, 0, 1'b0);
    wait_drain();

    // Backpressure
    bus.out_ready = 1'b0;
    send_word(8'b1101_0000, 1, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clock); #1; n++;
    end
    chk("bp_out_valid_seen", int'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_out_count", int'(bus.out_count), 1);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      bus.in_valid = (i % 2 == 0);
      bus.in_word  = 8'hFF;
      @(posedge clock); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_hold_before_release", int'(bus.out_valid), 1);
    @(posedge clock); #1;
    chk("bp_idle_in_ready", int'(bus.in_ready), 1);
    chk("bp_idle_out_valid", int'(bus.out_valid), 0);
    repeat (3) begin
      @(posedge clock); #1;
      chk("bp_no_ghost_word", int'(bus.det_reset), 0);
    end

    // Saturation on the 32-bit / 2-bit-counter instance
    bus32.in_valid = 1'b1;
    bus32.in_word  = 32'hDDDD_DDDD;
    chk("sat_in_ready", int'(bus32.in_ready), 1);
    exp_q32.push_back(3);
    @(posedge clock); #1;
    bus32.in_valid = 1'b0;
    wait_drain();

    // Reset during SHIFT bit 3
    send_word(8'b1101_0000, 1, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    chk("rst_mid_det_w_bit3", int'(bus.det_w), 1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outputs("rst_mid");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clock); #1;
      if (bus.out_valid) seen++;
    end
    chk("rst_no_result", seen, 0);
    send_word(8'b1101_0000, 1, 1'b1);
    wait_drain();

    // Back-to-back with in_valid held high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_word   = 8'b1101_1101;
    wait_in_ready();
    exp_q.push_back(2);
    @(posedge clock); #1;
    bus.in_word = 8'b1110_1000;
    chk("b2b_first_clear", int'(bus.det_reset), 1);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      chk("b2b_not_accepted_early", int'(bus.in_ready), 0);
      @(posedge clock); #1; n++;
    end
    chk("b2b_out_valid_seen", int'(bus.out_valid), 1);
    @(posedge clock); #1;
    chk("b2b_idle_in_ready", int'(bus.in_ready), 1);
    chk("b2b_idle_det_reset", int'(bus.det_reset), 0);
    exp_q.push_back(1);
    @(posedge clock); #1;
    chk("b2b_second_clear", int'(bus.det_reset), 1);
    chk("b2b_second_busy", int'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
